// File: rtl/average_arbiter_if.sv
// Requester-side bundle for the shared averaging arbiter: request/sample
// inputs and per-requester grant/result outputs.
interface average_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   valid;
   logic [NREQ*W-1:0] num;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      ave;
   logic [NREQ-1:0]   done;
   logic              busy;

   modport master (output req, valid, num, input gnt, ave, done, busy);
   modport slave  (input req, valid, num, output gnt, ave, done, busy);
endinterface

// File: rtl/average_arbiter.sv
// Round-robin owner of a single burst averaging accumulator; returns the floor
// average of a full or early-terminated burst to the granted requester.
module average_arbiter #(
   parameter int NREQ  = 4,
   parameter int W     = 4,
   parameter int BURST = 8
) (
   input logic               clk,
   input logic               rst_n,
   average_arbiter_if.slave  bus
);
   localparam int LB = $clog2(BURST);
   localparam int SW = W + LB;
   localparam int CW = LB + 1;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   logic [0:0]      state_r, state_n;
   logic [NREQ-1:0] gnt_r, gnt_n;
   logic [NREQ-1:0] done_r, done_n;
   logic [W-1:0]    ave_r, ave_n;
   logic            busy_r, busy_n;
   logic [SW-1:0]   sum_r, sum_n;
   logic [CW-1:0]   count_r, count_n;
   logic [PW-1:0]   ptr_r, ptr_n;

   logic            pick_found_s;
   logic [PW-1:0]   pick_idx_s;
   logic [W-1:0]    sample_s;
   logic [SW-1:0]   sum_next_s;
   logic [CW-1:0]   count_next_s;
   logic [CW-1:0]   divisor_s;
   logic [SW-1:0]   quot_s;
   logic [W-1:0]    part_ave_s;
   logic [W-1:0]    full_ave_s;

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin search: first requesting index after the last grant, wrapping.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = ptr_r;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(ptr_r) + k) % NREQ;
         if (!pick_found_s && bus.req[idx]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = PW'(idx);
         end else begin
            pick_idx_s   = pick_idx_s;
         end
      end
   end

   // Datapath for the granted requester's sample and both averaging forms.
   always_comb begin
      sample_s     = bus.num[int'(ptr_r)*W +: W];
      sum_next_s   = sum_r + SW'(sample_s);
      count_next_s = count_r + CW'(1);
      if (count_r == '0) begin
         divisor_s = CW'(1);
      end else begin
         divisor_s = count_r;
      end
      quot_s     = sum_r / SW'(divisor_s);
      part_ave_s = quot_s[W-1:0];
      full_ave_s = W'(sum_next_s >> LB);
   end

   // Next-state logic; a REQ drop outranks a sample arriving on the same edge.
   always_comb begin
      state_n = state_r;
      gnt_n   = gnt_r;
      done_n  = '0;
      ave_n   = ave_r;
      sum_n   = sum_r;
      count_n = count_r;
      ptr_n   = ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_found_s) begin
               gnt_n   = onehot(pick_idx_s);
               ptr_n   = pick_idx_s;
               sum_n   = '0;
               count_n = '0;
               state_n = ST_ACCUM;
            end else begin
               gnt_n   = '0;
            end
         end
         ST_ACCUM: begin
            if (!bus.req[ptr_r]) begin
               if (count_r != '0) begin
                  ave_n  = part_ave_s;
                  done_n = onehot(ptr_r);
               end else begin
                  done_n = '0;
               end
               gnt_n   = '0;
               state_n = ST_IDLE;
            end else if (bus.valid[ptr_r]) begin
               sum_n   = sum_next_s;
               count_n = count_next_s;
               if (count_next_s == CW'(BURST)) begin
                  ave_n   = full_ave_s;
                  done_n  = onehot(ptr_r);
                  gnt_n   = '0;
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_ACCUM;
               end
            end else begin
               state_n = ST_ACCUM;
            end
         end
         default: begin
            gnt_n   = '0;
            state_n = ST_IDLE;
         end
      endcase
      busy_n = (state_n == ST_ACCUM);
   end

   // State and registered outputs; reset restores the pointer so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         gnt_r   <= '0;
         done_r  <= '0;
         ave_r   <= '0;
         busy_r  <= 1'b0;
         sum_r   <= '0;
         count_r <= '0;
         ptr_r   <= PW'(NREQ - 1);
      end else begin
         state_r <= state_n;
         gnt_r   <= gnt_n;
         done_r  <= done_n;
         ave_r   <= ave_n;
         busy_r  <= busy_n;
         sum_r   <= sum_n;
         count_r <= count_n;
         ptr_r   <= ptr_n;
      end
   end

   assign bus.gnt  = gnt_r;
   assign bus.done = done_r;
   assign bus.ave  = ave_r;
   assign bus.busy = busy_r;
endmodule

// File: tb/tb_average_arbiter.sv
// Directed bench for average_arbiter with NREQ=4, W=4, BURST=8.
module tb_average_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   average_arbiter_if #(.NREQ(4), .W(4)) bus ();

   average_arbiter #(.NREQ(4), .W(4), .BURST(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req   = 4'b0000;
      bus.valid = 4'b0000;
      bus.num   = 16'h0000;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.ave !== 4'd0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_state gnt=%b done=%b ave=%0d busy=%b expected all zero",
                  bus.gnt, bus.done, bus.ave, bus.busy);
      end
      rst_n = 1'b1;
      bus.req = 4'b1111;
      tick();
      checks++;
      if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL first_grant gnt=%b busy=%b expected 0001 1", bus.gnt, bus.busy);
      end
      bus.req = 4'b0000;
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL empty_drop gnt=%b done=%b busy=%b expected 0000 0000 0",
                  bus.gnt, bus.done, bus.busy);
      end
   endtask

   task automatic test_full_burst();
      bus.req = 4'b0010;
      tick();
      checks++;
      if (bus.gnt !== 4'b0010) begin
         failures++;
         $display("FAIL full_grant gnt=%b expected 0010", bus.gnt);
      end
      bus.valid = 4'b0010;
      for (int i = 1; i <= 8; i++) begin
         bus.num = 16'(i) << 4;
         tick();
         if (i < 8) begin
            checks++;
            if (bus.done !== 4'b0000 || bus.gnt !== 4'b0010) begin
               failures++;
               $display("FAIL full_mid%0d done=%b gnt=%b expected 0000 0010", i, bus.done, bus.gnt);
            end
         end else begin
            checks++;
            if (bus.ave !== 4'd4 || bus.done !== 4'b0010 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
               failures++;
               $display("FAIL full_result ave=%0d done=%b gnt=%b busy=%b expected 4 0010 0000 0",
                        bus.ave, bus.done, bus.gnt, bus.busy);
            end
         end
      end
      idle_inputs();
      tick();
      checks++;
      if (bus.done !== 4'b0000) begin
         failures++;
         $display("FAIL full_done_clear done=%b expected 0000", bus.done);
      end
   endtask

   task automatic test_partial();
      logic [3:0] samples [3];
      samples[0] = 4'd5;
      samples[1] = 4'd6;
      samples[2] = 4'd7;
      bus.req = 4'b0100;
      tick();
      bus.valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         bus.num = 16'(samples[i]) << 8;
         tick();
      end
      idle_inputs();
      tick();
      checks++;
      if (bus.ave !== 4'd6 || bus.done !== 4'b0100 || bus.gnt !== 4'b0000) begin
         failures++;
         $display("FAIL partial_result ave=%0d done=%b gnt=%b expected 6 0100 0000",
                  bus.ave, bus.done, bus.gnt);
      end
      tick();
      bus.req = 4'b0100;
      tick();
      bus.req = 4'b0000;
      tick();
      checks++;
      if (bus.done !== 4'b0000 || bus.ave !== 4'd6 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL partial_empty done=%b ave=%0d gnt=%b busy=%b expected 0000 6 0000 0",
                  bus.done, bus.ave, bus.gnt, bus.busy);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] order [4];
      order[0] = 4'b0001;
      order[1] = 4'b0010;
      order[2] = 4'b1000;
      order[3] = 4'b0001;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.req   = 4'b1011;
      bus.valid = 4'b1011;
      bus.num   = 16'hFFFF;
      for (int b = 0; b < 4; b++) begin
         tick();
         checks++;
         if (bus.gnt !== order[b] || bus.done !== 4'b0000) begin
            failures++;
            $display("FAIL rr_grant%0d gnt=%b done=%b expected %b 0000", b, bus.gnt, bus.done, order[b]);
         end
         for (int s = 1; s <= 8; s++) begin
            tick();
         end
         checks++;
         if (bus.ave !== 4'd15 || bus.done !== order[b] || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL rr_result%0d ave=%0d done=%b gnt=%b expected 15 %b 0000",
                     b, bus.ave, bus.done, bus.gnt, order[b]);
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_gaps();
      int accepted;
      accepted = 0;
      bus.req = 4'b0001;
      tick();
      checks++;
      if (bus.gnt !== 4'b0001) begin
         failures++;
         $display("FAIL gaps_grant gnt=%b expected 0001", bus.gnt);
      end
      for (int c = 0; c < 22; c++) begin
         if (c % 3 == 0) begin
            bus.valid = 4'b1001;
            bus.num   = 16'hF002;
            accepted++;
         end else begin
            bus.valid = 4'b1000;
            bus.num   = 16'hF00F;
         end
         tick();
         if (accepted < 8) begin
            if (bus.done !== 4'b0000) begin
               checks++;
               failures++;
               $display("FAIL gaps_early_done cycle=%0d done=%b expected 0000", c, bus.done);
            end
         end
      end
      checks++;
      if (bus.ave !== 4'd2 || bus.done !== 4'b0001 || bus.gnt !== 4'b0000) begin
         failures++;
         $display("FAIL gaps_result ave=%0d done=%b gnt=%b expected 2 0001 0000",
                  bus.ave, bus.done, bus.gnt);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_precedence();
      bus.req = 4'b0001;
      tick();
      bus.valid = 4'b0001;
      bus.num   = 16'h0004;
      for (int i = 0; i < 3; i++) begin
         tick();
      end
      bus.req = 4'b0000;
      bus.num = 16'h0009;
      tick();
      checks++;
      if (bus.ave !== 4'd4 || bus.done !== 4'b0001 || bus.gnt !== 4'b0000) begin
         failures++;
         $display("FAIL precedence ave=%0d done=%b gnt=%b expected 4 0001 0000",
                  bus.ave, bus.done, bus.gnt);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      bus.req   = 4'b0001;
      tick();
      bus.valid = 4'b0001;
      bus.num   = 16'h0003;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.ave !== 4'd0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid gnt=%b done=%b ave=%0d busy=%b expected all zero",
                  bus.gnt, bus.done, bus.ave, bus.busy);
      end
      #2;
      rst_n = 1'b1;
      bus.req   = 4'b1111;
      bus.valid = 4'b0000;
      tick();
      checks++;
      if (bus.gnt !== 4'b0001) begin
         failures++;
         $display("FAIL reset_pointer gnt=%b expected 0001", bus.gnt);
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_full_burst();
      test_partial();
      test_round_robin();
      test_gaps();
      test_precedence();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
